// File: rtl/tsp_dump_arbiter.sv
// tsp_dump_arbiter: round-robin burst reader from NUM_CH FIFOs into one AXI-Stream,
// with a 2-entry skid buffer that absorbs the 1-cycle FIFO read latency.
module tsp_dump_arbiter #(
    parameter int NUM_CH               = 4,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int BULK_OF_DATA         = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   enable,
    input  logic [NUM_CH-1:0]                      ch_r_ready,
    output logic [NUM_CH-1:0]                      ch_r_enable,
    input  logic [NUM_CH*C_M_AXIS_TDATA_WIDTH-1:0] ch_rdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]        m_axis_tdata,
    output logic                                   m_axis_tlast,
    output logic [2:0]                             m_axis_tuser,
    output logic [NUM_CH-1:0]                      cur_grant
);
    localparam int W  = C_M_AXIS_TDATA_WIDTH;
    localparam int CW = $clog2(BULK_OF_DATA) + 1;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [2:0]        idx_q, idx_d, ptr_q, ptr_d, sel;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        fill_q, fill_d, fill_p, infl_q;
    logic              infl_last_q;
    logic [W:0]        buf0_q, buf0_d, buf1_q, buf1_d, word;
    logic [W-1:0]      rd [8];
    logic [7:0]        rdy;
    logic [3:0]        s;
    logic              pop, push, strobe, last_strobe;

    for (genvar g = 0; g < 8; g++) begin : g_rd
        if (g < NUM_CH) begin : g_ch
            assign rd[g] = ch_rdata[g*W +: W];
        end else begin : g_pad
            assign rd[g] = '0;
        end
    end

    assign rdy           = 8'(ch_r_ready);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign push          = infl_q != 2'd0;
    assign m_axis_tvalid = fill_q != 2'd0;
    assign m_axis_tdata  = buf0_q[W-1:0];
    assign m_axis_tlast  = m_axis_tvalid & buf0_q[W];
    assign m_axis_tuser  = idx_q;
    assign cur_grant     = grant_q;
    // a word leaving this cycle frees its slot for a new read
    assign strobe        = state_q == BURST &&
                           ({1'b0, fill_q} + {1'b0, infl_q} - {2'b0, pop}) < 3'd2;
    assign last_strobe   = strobe && cnt_q == CW'(BULK_OF_DATA - 1);
    assign ch_r_enable   = strobe ? grant_q : '0;
    assign word          = {infl_last_q, rd[idx_q]};

    // descending scan so the channel closest to ptr_q wins
    always_comb begin
        sel = '0;
        s   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            s   = 4'(ptr_q) + 4'(i);
            s   = s >= 4'(NUM_CH) ? s - 4'(NUM_CH) : s;
            sel = rdy[s[2:0]] ? s[2:0] : sel;
        end
    end

    always_comb begin
        fill_p = fill_q - {1'b0, pop};
        buf0_d = (push && fill_p == 2'd0) ? word : pop ? buf1_q : buf0_q;
        buf1_d = (push && fill_p == 2'd1) ? word : buf1_q;
        fill_d = fill_p + {1'b0, push};
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q + CW'(strobe);
        case (state_q)
            IDLE: if (enable && |ch_r_ready) begin
                state_d = BURST;
                grant_d = NUM_CH'(1) << sel;
                idx_d   = sel;
                ptr_d   = (sel == 3'(NUM_CH - 1)) ? 3'd0 : sel + 3'd1;
                cnt_d   = '0;
            end
            BURST: state_d = last_strobe ? DRAIN : BURST;
            DRAIN: if (fill_d == 2'd0 && infl_q == 2'd0) begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            fill_q      <= '0;
            infl_q      <= '0;
            infl_last_q <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            infl_q      <= {1'b0, strobe};
            infl_last_q <= last_strobe;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end
endmodule

// File: doc/tsp_dump_arbiter.md
TSP_DUMP_ARBITER -- requirements
Module: tsp_dump_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of FIFO channels, range 2..8.
REQ-002 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, giving the word width of the FIFOs and the stream.
REQ-003 SHALL have parameter BULK_OF_DATA, default 16, giving the words per burst; one channel r_ready guarantees this many readable words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, equal to the FIFO read clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1 bit: 0 stops new grants; a running burst completes.
REQ-007 SHALL have port ch_r_ready, input, NUM_CH bits: per-channel "bulk available".
REQ-008 SHALL have port ch_r_enable, output, NUM_CH bits: per-channel one-word read strobe.
REQ-009 SHALL have port ch_rdata, input, NUM_CH*C_M_AXIS_TDATA_WIDTH bits: channel i occupies slice [i*W +: W].
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit: AXI-Stream valid.
REQ-011 SHALL have port m_axis_tready, input, 1 bit: AXI-Stream ready.
REQ-012 SHALL have port m_axis_tdata, output, C_M_AXIS_TDATA_WIDTH bits: stream data.
REQ-013 SHALL have port m_axis_tlast, output, 1 bit: marks the last word of a burst.
REQ-014 SHALL have port m_axis_tuser, output, 3 bits: channel index of the current word.
REQ-015 SHALL have port cur_grant, output, NUM_CH bits: one-hot granted channel; all zero when idle.

Function
REQ-016 SHALL implement states IDLE, BURST and DRAIN.
- IDLE -> BURST when enable=1 and any ch_r_ready=1.
- BURST -> DRAIN after the BULK_OF_DATA-th read strobe.
- DRAIN -> IDLE when the output buffer is empty.
REQ-017 SHALL grant round-robin in IDLE.
- Search starts at (last granted index + 1) mod NUM_CH.
- After reset the search starts at index 0.
- Grant is registered: cur_grant is valid on the cycle BURST is entered.
REQ-018 SHALL sample ch_r_ready only in IDLE; deassertion during BURST does not abort the burst.
REQ-019 SHALL treat FIFO read latency as 1 cycle: data for a strobe at cycle t is taken from ch_rdata of the granted channel at t+1.
REQ-020 SHALL contain a 2-entry output buffer and keep a 2-bit in-flight count.
- A strobe is issued only in BURST when (buffered words + in-flight reads) < 2, counting a word popped this cycle as freed.
- At most one strobe per cycle, and only on the granted channel.
REQ-021 SHALL sustain 1 word/cycle while m_axis_tready=1: BULK_OF_DATA words in BULK_OF_DATA+2 cycles from grant to tlast.
REQ-022 SHALL hold m_axis_tdata, tlast and tuser stable while tvalid=1 and tready=0; tvalid SHALL never drop without a handshake.
REQ-023 SHALL assert m_axis_tlast only on the BULK_OF_DATA-th word of a burst; tuser equals the granted index on every word.
REQ-024 SHALL use a burst word counter of $clog2(BULK_OF_DATA)+1 bits that clears on grant.
REQ-025 SHALL leave at least one IDLE cycle between bursts, so cur_grant is all zero for at least one cycle after tlast.
REQ-026 SHALL, when enable falls mid-burst, complete the burst including tlast, then stay in IDLE.
REQ-027 SHALL, when ch_r_ready is asserted on several channels in the same cycle, grant exactly one of them per REQ-017.

Reset
REQ-028 SHALL, with rst_n=0 asynchronously and regardless of clk, set:
- state to IDLE;
- ch_r_enable, cur_grant, m_axis_tvalid, m_axis_tlast, m_axis_tuser and m_axis_tdata to 0;
- the counters and output buffer to empty;
- the round-robin pointer to the value that makes channel 0 next.
REQ-029 SHALL discard a burst in progress on mid-burst reset; after release the first grant again starts the search at channel 0.
REQ-030 SHALL issue no strobe in the first clk cycle after rst_n rises.

Verification
REQ-031 Single burst: ch_r_ready=0001, tready=1, data = word index -> 16 words 0..15, tuser=0, tlast only on word 15, 18 cycles from grant.
REQ-032 Round-robin: ch_r_ready=1111 held -> burst order ch0, ch1, ch2, ch3, ch0; cur_grant one-hot; at least one idle cycle between bursts.
REQ-033 Backpressure: tready toggles 1,0,0,1 repeating -> no word lost or duplicated, data held while stalled, at most 2 outstanding strobes, exactly 16 ch_r_enable pulses.
REQ-034 Enable drop: enable goes 0 after the 5th strobe -> all 16 words and tlast delivered, then IDLE with no new grant while ch_r_ready=1.
REQ-035 Reset mid-burst: rst_n low at word 7 -> tvalid=0 and ch_r_enable=0 immediately; after release with ch_r_ready=0100, the next grant is ch2.
REQ-036 Skip: ch_r_ready=1010 after a ch1 burst -> next grant is ch3, then ch1.
